// File: rtl/bus_dev_fifo.sv
// Bus device port with a TX FIFO (agent -> bus) and an RX FIFO (bus -> monitor).
// Both FIFOs are first-word-fall-through: the head entry is visible on the
// output as soon as it is stored, and the output reads zero while empty.
//
// Ports:
//   clk, reset           single clock, asynchronous active-high reset
//   wr_en, wr_data       agent loads a packet into the TX FIFO
//   tx_full              TX FIFO holds depth entries
//   pndng, D_pop         TX FIFO non-empty flag and head packet, to the bus
//   pop                  bus consumed the TX head
//   push, D_push         bus delivers a packet into the RX FIFO
//   rd_en                monitor removes the RX head
//   rd_data              RX FIFO head packet
//   rx_empty, rx_count   RX FIFO empty flag and occupancy
//   err                  sticky flags: [0] overflow, [1] underflow, [2] misaddressed
module bus_dev_fifo #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [pckg_sz-1:0]       wr_data,
  output logic                     tx_full,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  input  logic                     rd_en,
  output logic [pckg_sz-1:0]       rd_data,
  output logic                     rx_empty,
  output logic [$clog2(depth):0]   rx_count,
  output logic [2:0]               err
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // with all depth entries in use.
  logic [AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [2:0]  err_q, err_d;

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];

  logic tx_empty, tx_full_int, rx_full;
  logic tx_wr_ok, tx_pop_ok, rx_wr_ok, rx_rd_ok;
  logic ovf, unf, misaddr;
  logic [7:0] dest;

  assign tx_empty    = (tx_wptr_q == tx_rptr_q);
  assign tx_full_int = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                       (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign rx_empty    = (rx_wptr_q == rx_rptr_q);
  assign rx_full     = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                       (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

  // A write into a full FIFO is accepted only if the head leaves in the same
  // cycle; a pop on an empty FIFO never happens, even alongside a write.
  assign tx_pop_ok = pop & ~tx_empty;
  assign tx_wr_ok  = wr_en & (~tx_full_int | pop);
  assign rx_rd_ok  = rd_en & ~rx_empty;
  assign rx_wr_ok  = push & (~rx_full | rd_en);

  assign dest    = D_push[pckg_sz-1 -: 8];
  assign ovf     = (wr_en & tx_full_int & ~pop) | (push & rx_full & ~rd_en);
  assign unf     = (pop & tx_empty) | (rd_en & rx_empty);
  assign misaddr = push & (dest != id) & (dest != broadcast);

  always_comb begin
    tx_wptr_d = tx_wr_ok  ? tx_wptr_q + PtrOne : tx_wptr_q;
    tx_rptr_d = tx_pop_ok ? tx_rptr_q + PtrOne : tx_rptr_q;
    rx_wptr_d = rx_wr_ok  ? rx_wptr_q + PtrOne : rx_wptr_q;
    rx_rptr_d = rx_rd_ok  ? rx_rptr_q + PtrOne : rx_rptr_q;
    err_d     = err_q | {misaddr, unf, ovf};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      err_q     <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: contents are only observable between the pointers.
  always_ff @(posedge clk) begin
    if (tx_wr_ok && !reset) tx_mem[tx_wptr_q[AW-1:0]] <= wr_data;
    if (rx_wr_ok && !reset) rx_mem[rx_wptr_q[AW-1:0]] <= D_push;
  end

  assign tx_full  = tx_full_int;
  assign pndng    = ~tx_empty;
  assign D_pop    = tx_empty ? '0 : tx_mem[tx_rptr_q[AW-1:0]];
  assign rd_data  = rx_empty ? '0 : rx_mem[rx_rptr_q[AW-1:0]];
  assign rx_count = rx_wptr_q - rx_rptr_q;
  assign err      = err_q;

endmodule

// File: doc/bus_dev_fifo.md
BUS_DEV_FIFO -- requirements
Module: bus_dev_fifo

Interface
REQ-001 SHALL have parameter pckg_sz, default 16, packet width in bits.
REQ-002 SHALL have parameter depth, default 8, entries per FIFO, power of two, at least 2.
REQ-003 SHALL have parameter id, default 0, 8-bit device identifier of this bus port.
REQ-004 SHALL have parameter broadcast, default 8'hFF, destination ID accepted by all devices.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, agent request to load a packet into the TX FIFO.
REQ-008 SHALL have port wr_data, input, pckg_sz, packet to transmit; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
REQ-009 SHALL have port tx_full, output, 1, TX FIFO holds depth entries.
REQ-010 SHALL have port pndng, output, 1, TX FIFO non-empty; goes to the bus.
REQ-011 SHALL have port D_pop, output, pckg_sz, TX FIFO head packet; goes to the bus.
REQ-012 SHALL have port pop, input, 1, bus consumed the head packet.
REQ-013 SHALL have port push, input, 1, bus delivers a packet to this device.
REQ-014 SHALL have port D_push, input, pckg_sz, delivered packet.
REQ-015 SHALL have port rd_en, input, 1, monitor removes the RX FIFO head.
REQ-016 SHALL have port rd_data, output, pckg_sz, RX FIFO head packet.
REQ-017 SHALL have port rx_empty, output, 1, RX FIFO holds no entries.
REQ-018 SHALL have port rx_count, output, $clog2(depth)+1, RX FIFO occupancy.
REQ-019 SHALL have port err, output, 3, sticky flags: [0] overflow, [1] underflow, [2] misaddressed.

Function
REQ-020 TX FIFO SHALL be first-word-fall-through: D_pop equals the oldest entry whenever pndng=1.
REQ-021 D_pop SHALL be all zeros when pndng=0.
REQ-022 A write accepted at edge N SHALL make pndng=1 and D_pop valid immediately after edge N, giving one-cycle latency.
REQ-023 pop=1 with pndng=1 SHALL remove the head at the edge; the next entry, or pndng=0, SHALL appear immediately after that edge.
REQ-024 pop=1 with pndng=0 SHALL be ignored and SHALL set err[1].
REQ-025 wr_en=1 with tx_full=1 and pop=0 SHALL drop wr_data, leave the FIFO unchanged and set err[0].
REQ-026 wr_en=1 and pop=1 in the same cycle with tx_full=1 SHALL perform both; occupancy stays depth.
REQ-027 wr_en=1 and pop=1 in the same cycle with the TX FIFO empty SHALL accept the write and ignore the pop (err[1] set).
REQ-028 push=1 SHALL write D_push into the RX FIFO when it is not full.
REQ-029 push=1 into a full RX FIFO with rd_en=0 SHALL drop D_push and set err[0]; push=1 and rd_en=1 on a full RX FIFO SHALL perform both.
REQ-030 push=1 where D_push[pckg_sz-1:pckg_sz-8] is neither id nor broadcast SHALL still be stored and SHALL set err[2].
REQ-031 rd_en=1 with rx_empty=1 SHALL be ignored and SHALL set err[1].
REQ-032 rd_data SHALL be first-word-fall-through, showing the oldest RX entry, and SHALL be zero when rx_empty=1.
REQ-033 Read and write pointers SHALL wrap modulo depth.
REQ-034 Full and empty SHALL be derived from an extra pointer wrap bit so that all depth entries are usable.
REQ-035 err bits SHALL remain set until reset.

Reset
REQ-036 reset=1 SHALL immediately, without waiting for a clock edge, clear both FIFOs and all pointers.
REQ-037 During reset: pndng=0, D_pop=0, tx_full=0, rx_empty=1, rx_count=0, rd_data=0, err=0.
REQ-038 Reset asserted mid-operation SHALL discard all stored packets.
REQ-039 All inputs SHALL be ignored while reset=1.
REQ-040 The first edge after reset deassertion SHALL accept wr_en and push.

Verification
REQ-041 Write 16'h0201, then 16'h0302, with no pop -> pndng=1; D_pop=16'h0201; one pop -> D_pop=16'h0302; second pop -> pndng=0, D_pop=0.
REQ-042 Write 9 packets with depth=8 and no pop -> tx_full=1 after the 8th; the 9th is dropped; err=3'b001; draining returns the first 8 packets in order.
REQ-043 With id=2, push 16'h02AA, then 16'hFF55, then 16'h0711 -> rx_count=3; err[2]=1 only after 16'h0711; reads return all three in order.
REQ-044 pop with an empty TX FIFO -> err[1]=1; pndng stays 0.
REQ-045 Fill the TX FIFO, then hold wr_en=1 and pop=1 for 20 cycles -> tx_full stays 1, no err[0], output order preserved across pointer wrap.
REQ-046 Assert reset asynchronously mid-cycle with 5 TX and 3 RX entries -> pndng=0, rx_empty=1, err=0 before the next edge.
